// File: rtl/rom_read_arbiter_pkg.sv
// rtl/rom_read_arbiter_pkg.sv - shared widths, state and requester id constants
package rom_read_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 3;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_read_arbiter_array8.sv
// rtl/rom_read_arbiter_array8.sv - fixed-content ROM with one-cycle registered read
//
// Module rom_array8
//   clk  : read clock
//   addr : word address
//   data : word at the address presented on the previous rising edge
// Contents are mem[i] = i + 1. There is no reset; the output holds its last read.
module rom_array8 #(
    parameter int ADDR_W = rom_read_arbiter_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W = rom_read_arbiter_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Storage table written out so the contents are visible to synthesis as a ROM.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i] = DATA_W'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin arbiter sharing one 8x8 ROM between two burst readers
//
// Ports
//   clk, rst                          : clock, synchronous active-low reset
//   req{0,1}_valid/_addr/_len/_ready  : burst request (start address, beats-1), ready = accept
//   rsp{0,1}_valid/_data/_last        : per-requester response beats, data 0 when idle
//   busy                              : burst being issued or a response beat still in flight
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_last,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_last,
    output logic              busy
);

    logic              state;
    logic              state_next;
    logic              last_id;    // requester served by the most recent completed burst
    logic              id;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  cnt;
    logic              pipe_valid;
    logic              pipe_id;
    logic              pipe_last;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [DATA_W-1:0] rom_data;

    rom_array8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk  (clk),
        .addr (cur_addr),
        .data (rom_data)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || (last_id == REQ1));
        grant1 = req1_valid && (!req0_valid || (last_id == REQ0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)        state_next = ST_BURST;
            ST_BURST: if (cnt == '0)     state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // Output logic; ready is held low while reset is asserted.
    always_comb begin
        req0_ready = rst && (state == ST_IDLE) && grant0;
        req1_ready = rst && (state == ST_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
    end

    // Burst counters and the response pipe stage aligned with the ROM read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid <= 1'b0;
            pipe_id    <= REQ0;
            pipe_last  <= 1'b0;
            last_id    <= REQ1;
            id         <= REQ0;
            cur_addr   <= '0;
            cnt        <= '0;
        end else begin
            pipe_valid <= (state == ST_BURST);
            if (state == ST_BURST) begin
                pipe_id   <= id;
                pipe_last <= (cnt == '0);
                cur_addr  <= cur_addr + ADDR_W'(1);
                cnt       <= cnt - LEN_W'(1);
                if (cnt == '0) begin
                    last_id <= id;
                end
            end else if (accept) begin
                id       <= req1_ready ? REQ1 : REQ0;
                cur_addr <= req1_ready ? req1_addr : req0_addr;
                cnt      <= req1_ready ? req1_len : req0_len;
            end
        end
    end

    always_comb begin
        rsp0_valid = pipe_valid && (pipe_id == REQ0);
        rsp1_valid = pipe_valid && (pipe_id == REQ1);
        rsp0_data  = rsp0_valid ? rom_data : '0;
        rsp1_data  = rsp1_valid ? rom_data : '0;
        rsp0_last  = rsp0_valid && pipe_last;
        rsp1_last  = rsp1_valid && pipe_last;
        busy       = (state == ST_BURST) || pipe_valid;
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - self-checking bench for rom_read_arbiter
module tb_rom_read_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic [2:0] req0_addr = '0;
    logic [2:0] req0_len = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [2:0] req1_addr = '0;
    logic [2:0] req1_len = '0;
    logic       req1_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       rsp0_last;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic       rsp1_last;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    rom_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_last  (rsp0_last),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_last  (rsp1_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic settle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd0; req0_len = 3'd0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0 ||
                rsp0_valid !== 1'b0 || rsp0_data !== 8'd0 || rsp0_last !== 1'b0 ||
                rsp1_valid !== 1'b0 || rsp1_data !== 8'd0 || rsp1_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: ready=%b%b busy=%b rsp0=%b/%h/%b rsp1=%b/%h/%b, required all 0",
                         i, req1_ready, req0_ready, busy, rsp0_valid, rsp0_data, rsp0_last,
                         rsp1_valid, rsp1_data, rsp1_last);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: req0_ready=%b required 1", req0_ready);
        end
        settle(4);
    endtask

    task automatic test_single_beat();
        req0_valid = 1'b1; req0_addr = 3'd2; req0_len = 3'd0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: ready=%b%b required 01", req1_ready, req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: rsp0_valid=%b rsp1_valid=%b required 0", rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 8'd3 || rsp0_last !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: rsp0=%b/%h/%b rsp1_valid=%b required 1/03/1 and 0",
                     rsp0_valid, rsp0_data, rsp0_last, rsp1_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: rsp0_valid=%b busy=%b required 0", rsp0_valid, busy);
        end
        settle(2);
    endtask

    task automatic test_wrap_burst();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'd7; exp_d[1] = 8'd8; exp_d[2] = 8'd1; exp_d[3] = 8'd2;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_len = 3'd3;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrap_accept: ready=%b%b required 10", req1_ready, req0_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== exp_d[k] || rsp1_last !== (k == 3) ||
                rsp0_valid !== 1'b0) begin
                errors++;
                $display("FAIL wrap_beat%0d: rsp1=%b/%h/%b rsp0_valid=%b required 1/%h/%b and 0",
                         k, rsp1_valid, rsp1_data, rsp1_last, rsp0_valid, exp_d[k], k == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_busy_fall: busy=%b rsp1_valid=%b required 0", busy, rsp1_valid);
        end
        settle(2);
    endtask

    task automatic test_back_to_back();
        bit ev; bit el; logic [7:0] ed;
        req0_valid = 1'b1; req0_addr = 3'd4; req0_len = 3'd1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            ev = (k >= 2) && (((k - 2) % 3) < 2);
            el = (k >= 2) && (((k - 2) % 3) == 1);
            ed = ev ? (el ? 8'd6 : 8'd5) : 8'd0;
            checks++;
            if (req0_ready !== ((k % 3) == 0) || rsp0_valid !== ev || rsp0_data !== ed ||
                rsp0_last !== el || (k >= 1 && busy !== 1'b1)) begin
                errors++;
                $display("FAIL b2b k=%0d: ready=%b rsp0=%b/%h/%b busy=%b required %b %b/%h/%b busy=%b",
                         k, req0_ready, rsp0_valid, rsp0_data, rsp0_last, busy,
                         (k % 3) == 0, ev, ed, el, k >= 1);
            end
        end
        settle(8);
    endtask

    task automatic test_contention();
        bit er0; bit er1; bit ev0; bit ev1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_len = 3'd0;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_len = 3'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL contention_in_reset: ready=%b%b required 00", req1_ready, req0_ready);
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            er0 = (k % 4) == 0;
            er1 = (k % 4) == 2;
            ev0 = (k >= 2) && ((k - 2) % 4 == 0);
            ev1 = (k >= 2) && ((k - 2) % 4 == 2);
            checks++;
            if (req0_ready !== er0 || req1_ready !== er1 ||
                rsp0_valid !== ev0 || rsp0_data !== (ev0 ? 8'd2 : 8'd0) || rsp0_last !== ev0 ||
                rsp1_valid !== ev1 || rsp1_data !== (ev1 ? 8'd6 : 8'd0) || rsp1_last !== ev1) begin
                errors++;
                $display("FAIL contention k=%0d: ready=%b%b rsp0=%b/%h rsp1=%b/%h required %b%b %b/%h %b/%h",
                         k, req1_ready, req0_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
                         er1, er0, ev0, ev0 ? 8'd2 : 8'd0, ev1, ev1 ? 8'd6 : 8'd0);
            end
        end
        settle(4);
    endtask

    task automatic test_reset_mid_burst();
        req0_valid = 1'b1; req0_addr = 3'd0; req0_len = 3'd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_accept: req0_ready=%b required 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 8'(b + 1)) begin
                errors++;
                $display("FAIL midrst_beat%0d: rsp0=%b/%h required 1/%h", b, rsp0_valid, rsp0_data, 8'(b + 1));
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: rsp0_valid=%b busy=%b required 0", rsp0_valid, busy);
        end
        rst = 1'b1;
        req1_valid = 1'b1; req1_addr = 3'd3; req1_len = 3'd0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_fresh_accept: req1_ready=%b required 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: rsp0_valid=%b rsp1_valid=%b required 0", rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 8'd4 || rsp1_last !== 1'b1 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fresh_beat: rsp1=%b/%h/%b rsp0_valid=%b required 1/04/1 and 0",
                     rsp1_valid, rsp1_data, rsp1_last, rsp0_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_tail%0d: rsp0_valid=%b busy=%b required 0", i, rsp0_valid, busy);
            end
        end
    endtask

    // Reference model: the shared ROM is free again len+2 cycles after an accept,
    // beats land at accept+2+k with data ((addr+k) mod 8)+1, ties go to whoever
    // was not served last.
    task automatic test_random();
        int         next_free;
        int         last_sv;
        int         slot;
        int         id;
        bit         v [2];
        int         a [2];
        int         l [2];
        bit         ev [2][64];
        logic [7:0] ed [2][64];
        bit         el [2][64];
        bit         eb [64];
        bit         g [2];
        bit         idle;
        for (int s = 0; s < 64; s++) begin
            eb[s] = 0;
            for (int r = 0; r < 2; r++) begin
                ev[r][s] = 0; ed[r][s] = 8'd0; el[r][s] = 0;
            end
        end
        v[0] = 0; v[1] = 0; a[0] = 0; a[1] = 0; l[0] = 0; l[1] = 0;
        last_sv = 1;
        next_free = cyc;
        for (int n = 0; n < 440; n++) begin
            @(negedge clk);
            slot = cyc % 64;
            checks++;
            if (rsp0_valid !== ev[0][slot] || rsp0_data !== ed[0][slot] || rsp0_last !== el[0][slot]) begin
                errors++;
                $display("FAIL random_rsp0 n=%0d: %b/%h/%b required %b/%h/%b", n,
                         rsp0_valid, rsp0_data, rsp0_last, ev[0][slot], ed[0][slot], el[0][slot]);
            end
            checks++;
            if (rsp1_valid !== ev[1][slot] || rsp1_data !== ed[1][slot] || rsp1_last !== el[1][slot]) begin
                errors++;
                $display("FAIL random_rsp1 n=%0d: %b/%h/%b required %b/%h/%b", n,
                         rsp1_valid, rsp1_data, rsp1_last, ev[1][slot], ed[1][slot], el[1][slot]);
            end
            checks++;
            if (busy !== eb[slot]) begin
                errors++;
                $display("FAIL random_busy n=%0d: busy=%b required %b", n, busy, eb[slot]);
            end
            eb[slot] = 0;
            for (int r = 0; r < 2; r++) begin
                ev[r][slot] = 0; ed[r][slot] = 8'd0; el[r][slot] = 0;
            end
            for (int r = 0; r < 2; r++) begin
                if (!v[r]) begin
                    if (n < 400 && $urandom_range(0, 2) != 0) begin
                        v[r] = 1;
                        a[r] = $urandom_range(0, 7);
                        l[r] = $urandom_range(0, 7);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    a[r] = $urandom_range(0, 7);
                    l[r] = $urandom_range(0, 7);
                end
            end
            req0_valid = v[0]; req0_addr = 3'(a[0]); req0_len = 3'(l[0]);
            req1_valid = v[1]; req1_addr = 3'(a[1]); req1_len = 3'(l[1]);
            #1;
            idle = (cyc >= next_free);
            g[0] = idle && v[0] && (!v[1] || last_sv == 1);
            g[1] = idle && v[1] && (!v[0] || last_sv == 0);
            checks++;
            if (req0_ready !== g[0] || req1_ready !== g[1]) begin
                errors++;
                $display("FAIL random_ready n=%0d: ready=%b%b required %b%b", n,
                         req1_ready, req0_ready, g[1], g[0]);
            end
            if (g[0] || g[1]) begin
                id = g[1] ? 1 : 0;
                for (int k = 0; k <= l[id]; k++) begin
                    ev[id][(cyc + 2 + k) % 64] = 1;
                    ed[id][(cyc + 2 + k) % 64] = 8'(((a[id] + k) % 8) + 1);
                    el[id][(cyc + 2 + k) % 64] = (k == l[id]);
                end
                for (int c = cyc + 1; c <= cyc + 2 + l[id]; c++) eb[c % 64] = 1;
                next_free = cyc + l[id] + 2;
                last_sv = id;
                v[id] = 0;
            end
        end
        settle(2);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wrap_burst();
        test_back_to_back();
        test_contention();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one 8x8 byte ROM between two read requesters using round-robin arbitration.
- Each request is a burst of 1..8 beats from a 3-bit start address; the address wraps modulo 8.
- Data returns on a per-requester response channel, one cycle after each ROM address is issued.
- Sits between the ROM storage and client logic; the ROM is instantiated inside the block.

Parameters:
- ADDR_W, 3, ROM address width (depth = 2**ADDR_W = 8)
- DATA_W, 8, ROM word width
- LEN_W, 3, burst length field width; beats = len+1 (1..8)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has a pending burst
- req0_addr  in  ADDR_W  requester 0 start address
- req0_len  in  LEN_W  requester 0 beats minus one
- req0_ready  out  1  requester 0 burst accepted this cycle
- req1_valid / req1_addr / req1_len / req1_ready  same as requester 0, for requester 1
- rsp0_valid  out  1  response beat for requester 0
- rsp0_data  out  DATA_W  ROM word; 0 when rsp0_valid is low
- rsp0_last  out  1  final beat of the burst
- rsp1_valid / rsp1_data / rsp1_last  same as requester 0, for requester 1
- busy  out  1  burst in progress or response still in flight

Behaviour:
- Reset (rst low sampled at posedge):
  - state=IDLE, pipe_valid=0, prio pointer set so req0 wins the first tie.
  - All rsp outputs and busy are 0 from the next cycle.
  - req*_ready is forced to 0 while rst is low.
- Reset mid-burst aborts the burst. No further rsp beats are issued, including any beat already in the pipe.
- FSM states are IDLE and BURST.
- IDLE arbitration:
  - Exactly one reqN_valid: grant N.
  - Both valid: grant the requester not served last (round-robin).
  - reqN_ready = (state==IDLE) && grantN. This is combinational from valid and state.
- Accept is valid && ready. On accept, latch id, cur_addr=addr, cnt=len; the next state is BURST.
- BURST, each cycle:
  - rom_addr=cur_addr; pipe_valid<=1; pipe_id<=id; pipe_last<=(cnt==0).
  - cur_addr<=cur_addr+1 mod 8 (7 wraps to 0); cnt<=cnt-1.
  - When cnt==0: the next state is IDLE and the prio pointer records id.
- ROM sub-module: registered read, 1-cycle latency, contents mem[i]=i+1 (i=0..7), no reset.
- Response outputs:
  - rspN_valid = pipe_valid && pipe_id==N.
  - rspN_data = ROM output when rspN_valid, else 0.
  - rspN_last = rspN_valid && pipe_last.
- Latency:
  - Accept at cycle T; first rsp at T+2; beats consecutive; last beat at T+2+len.
  - The next accept is possible at T+len+2, so the last beat overlaps the next arbitration.
- No response back-pressure: requesters must sink every beat.
- Requesters hold valid/addr/len stable until ready. Changes before accept are legal; the values sampled on the accept cycle are used.
- Requester validity is not sampled during BURST, so a requester asserting valid mid-burst waits for IDLE.
- busy = (state==BURST) || pipe_valid.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W/LEN_W defaults.
  - State encoding constants ST_IDLE=1'b0, ST_BURST=1'b1.
  - Requester id constants REQ0=1'b0, REQ1=1'b1.
- One sub-module: rom_array8, the 8x8 registered-read storage with the fixed init contents.
- Arbitration, FSM, counters and response pipe stay in rom_read_arbiter.

Test Plan:
- Reset hold: rst=0 for 3 cycles with req0_valid=1, addr=0 -> req0_ready=0, rsp*=0, busy=0 throughout; after rst=1, req0_ready=1 in the first cycle.
- Single beat: req0 addr=2 len=0 accepted at T -> rsp0_valid only at T+2 with data=8'd3 and last=1; rsp1_valid stays 0.
- Wrap burst: req1 addr=6 len=3 -> rsp1_data=7,8,1,2 on 4 consecutive cycles, last=1 on the 4th only, busy falls the cycle after.
- Contention: both valid from reset, each len=0, held continuously -> grant order req0, req1, req0, req1; accepts every 2 cycles; rsp data matches each requester's address.
- Back-to-back: req0 alone with continuous valid, addr=4, len=1 -> accepts at T, T+3, T+6; rsp0 data 5,6 repeated at T+2/T+3, T+5/T+6; busy stays 1.
- Reset mid-burst: req0 addr=0 len=7, rst=0 after 3 beats (1,2,3) seen -> no further rsp beats; busy=0 the cycle after reset is sampled; a fresh req1 after rst=1 is served normally.
